// File: rtl/signed_cmp_arbiter.sv
//----------------------------------------------------------------------------
// Module      : signed_cmp_arbiter
// Description : Round-robin arbiter/sequencer that shares one registered
//               signed comparator among N_REQ requesters. A winner's operand
//               pair is latched onto cmp_a/cmp_b. The block waits CMP_LAT
//               cycles, then captures cmp_res into res and pulses done for
//               that requester.
// Ports       : clk      - rising-edge clock
//               reset    - asynchronous active-high reset
//               req      - level request per requester
//               a_bus    - operand a, requester i at [i*WIDTH +: WIDTH]
//               b_bus    - operand b, same packing
//               gnt      - one-hot grant, grant cycle through done cycle
//               done     - one-cycle pulse to the granted requester
//               res      - comparison result, valid in the done cycle
//               busy     - high whenever the sequencer is not idle
//               cmp_a    - registered operand a to the comparator
//               cmp_b    - registered operand b to the comparator
//               cmp_res  - result returned by the comparator
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module signed_cmp_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 4,
  parameter int CMP_LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_bus,
  input  logic [N_REQ*WIDTH-1:0] b_bus,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic                   res,
  output logic                   busy,
  output logic [WIDTH-1:0]       cmp_a,
  output logic [WIDTH-1:0]       cmp_b,
  input  logic                   cmp_res
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] LAT_LOAD  = CNT_W'(CMP_LAT);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0] GNT_ONE   = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [IDX_W-1:0] last_winner;

  // Unpack the operand buses so the winner can be selected by a narrow index.
  logic [WIDTH-1:0] a_arr [N_REQ];
  logic [WIDTH-1:0] b_arr [N_REQ];

  generate
    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
      assign a_arr[i] = a_bus[i*WIDTH +: WIDTH];
      assign b_arr[i] = b_bus[i*WIDTH +: WIDTH];
    end
  endgenerate

  // Round-robin search: candidates are visited starting one past the last
  // winner and wrapping, so the previous winner has the lowest priority.
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;

  always_comb begin : p_rr
    int               cand;
    logic [IDX_W-1:0] cidx;
    cand      = 0;
    cidx      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    win_a     = '0;
    win_b     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = int'(last_winner) + k;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      cidx = cand[IDX_W-1:0];
      if (!win_found && req[cidx]) begin
        win_found = 1'b1;
        win_idx   = cidx;
        win_a     = a_arr[cidx];
        win_b     = b_arr[cidx];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      last_winner <= LAST_INIT;
      gnt         <= '0;
      done        <= '0;
      res         <= 1'b0;
      busy        <= 1'b0;
      cmp_a       <= '0;
      cmp_b       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= '0;
          if (win_found) begin
            state       <= S_WAIT;
            gnt         <= GNT_ONE << win_idx;
            last_winner <= win_idx;
            cmp_a       <= win_a;
            cmp_b       <= win_b;
            wait_cnt    <= LAT_LOAD;
            busy        <= 1'b1;
          end else begin
            gnt  <= '0;
            busy <= 1'b0;
          end
        end
        S_WAIT: begin
          // The counter reaches zero in the cycle where cmp_res reflects
          // the operands latched at grant time.
          if (wait_cnt == '0) begin
            res   <= cmp_res;
            done  <= gnt;
            state <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        S_DONE: begin
          done  <= '0;
          gnt   <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          gnt   <= '0;
          done  <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_signed_cmp_arbiter.sv
//----------------------------------------------------------------------------
// Module      : tb_signed_cmp_arbiter
// Description : Directed self-checking bench for signed_cmp_arbiter. Three
//               instances (CMP_LAT = 1, 0, 3) share stimulus. Each one has
//               its own signed comparator model of matching latency.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_signed_cmp_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] a_bus;
  logic [15:0] b_bus;

  // CMP_LAT = 1 instance (main target)
  logic [3:0] gnt1, done1;
  logic       res1, busy1, cres1;
  logic [3:0] ca1, cb1;
  // CMP_LAT = 0 instance
  logic [3:0] gnt0, done0;
  logic       res0, busy0, cres0;
  logic [3:0] ca0, cb0;
  // CMP_LAT = 3 instance
  logic [3:0] gnt3, done3;
  logic       res3, busy3, cres3;
  logic [3:0] ca3, cb3;

  logic       p1_1;
  logic       p3_1, p3_2, p3_3;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  signed_cmp_arbiter #(.N_REQ(4), .WIDTH(4), .CMP_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .req(req), .a_bus(a_bus), .b_bus(b_bus),
    .gnt(gnt1), .done(done1), .res(res1), .busy(busy1),
    .cmp_a(ca1), .cmp_b(cb1), .cmp_res(cres1)
  );

  signed_cmp_arbiter #(.N_REQ(4), .WIDTH(4), .CMP_LAT(0)) dut0 (
    .clk(clk), .reset(reset), .req(req), .a_bus(a_bus), .b_bus(b_bus),
    .gnt(gnt0), .done(done0), .res(res0), .busy(busy0),
    .cmp_a(ca0), .cmp_b(cb0), .cmp_res(cres0)
  );

  signed_cmp_arbiter #(.N_REQ(4), .WIDTH(4), .CMP_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .req(req), .a_bus(a_bus), .b_bus(b_bus),
    .gnt(gnt3), .done(done3), .res(res3), .busy(busy3),
    .cmp_a(ca3), .cmp_b(cb3), .cmp_res(cres3)
  );

  // Comparator models: res = signed(a) > signed(b), with 0, 1 and 3 cycles.
  assign cres0 = ($signed(ca0) > $signed(cb0));

  initial begin
    p1_1 = 1'b0;
    p3_1 = 1'b0;
    p3_2 = 1'b0;
    p3_3 = 1'b0;
  end

  always @(posedge clk) begin
    p1_1 <= ($signed(ca1) > $signed(cb1));
    p3_1 <= ($signed(ca3) > $signed(cb3));
    p3_2 <= p3_1;
    p3_3 <= p3_2;
  end

  assign cres1 = p1_1;
  assign cres3 = p3_3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int idx, input logic [3:0] a, input logic [3:0] b);
    a_bus[idx*4 +: 4] = a;
    b_bus[idx*4 +: 4] = b;
  endtask

  // One isolated request on the CMP_LAT=1 instance, dropped after grant.
  task automatic run1(input string tag, input int idx, input logic [3:0] a,
                      input logic [3:0] b, input logic exp_res);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    set_ops(idx, a, b);
    req[idx] = 1'b1;
    step();                                   // t+1
    check({tag, "_gnt"}, gnt1, oh);
    check({tag, "_cmpa"}, ca1, a);
    check({tag, "_cmpb"}, cb1, b);
    req[idx] = 1'b0;
    step();                                   // t+2
    check({tag, "_nodone"}, done1, 4'b0000);
    step();                                   // t+3
    check({tag, "_done"}, done1, oh);
    check({tag, "_res"}, res1, exp_res);
    step();                                   // t+4, back in IDLE
    check({tag, "_idle"}, {gnt1, busy1}, 5'b0);
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    a_bus = '0;
    b_bus = '0;
    step();
    step();
    check("rst_gnt",  gnt1, 4'b0000);
    check("rst_done", done1, 4'b0000);
    check("rst_res",  res1, 1'b0);
    check("rst_busy", {busy0, busy1, busy3}, 3'b000);
    check("rst_cmp",  {ca1, cb1}, 8'h00);
    reset = 1'b0;
    step();

    // Single request and signed comparisons.
    run1("single",  0, 4'd4, 4'd1, 1'b1);
    run1("s_pos_m1", 0, 4'd4, 4'hF, 1'b1);
    run1("s_m1_pos", 0, 4'hF, 4'd4, 1'b0);
    run1("s_min_max", 3, 4'h8, 4'h7, 1'b0);
    run1("s_max_min", 2, 4'h7, 4'h8, 1'b1);
    run1("s_equal",  1, 4'h5, 4'h5, 1'b0);
    check("held_ops", {ca1, cb1}, 8'h55);

    // All four from reset, each held until its done.
    reset = 1'b1;
    #1;
    reset = 1'b0;
    step();
    set_ops(0, 4'd1, 4'd2);    // 1 > 2   -> 0
    set_ops(1, 4'hE, 4'hD);    // -2 > -3 -> 1
    set_ops(2, 4'd3, 4'd3);    // 3 > 3   -> 0
    set_ops(3, 4'd7, 4'h8);    // 7 > -8  -> 1
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("all_gnt%0d", k), gnt1, 4'b0001 << k);
      step();
      step();
      check($sformatf("all_done%0d", k), done1, 4'b0001 << k);
      check($sformatf("all_res%0d", k), res1, (k == 1 || k == 3) ? 1'b1 : 1'b0);
      req[k] = 1'b0;
      step();
      check($sformatf("all_idle%0d", k), busy1, 1'b0);
    end

    // Fairness: req[0] permanent, req[2] also pending.
    set_ops(2, 4'd3, 4'hF);    // 3 > -1 -> 1
    req = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("fair_gnt%0d", k), gnt1, (k % 2 == 0) ? 4'b0001 : 4'b0100);
      step();
      step();
      check($sformatf("fair_res%0d", k), res1, (k % 2 == 0) ? 1'b0 : 1'b1);
      step();
      if (k == 3) req = '0;
    end
    step();
    check("fair_end", busy1, 1'b0);

    // Operands change after grant.
    set_ops(1, 4'hD, 4'd2);    // -3 > 2 -> 0
    req[1] = 1'b1;
    step();                    // t+1
    check("late_gnt", gnt1, 4'b0010);
    req[1] = 1'b0;
    step();                    // t+2
    set_ops(1, 4'd7, 4'd2);
    step();                    // t+3
    check("late_done", done1, 4'b0010);
    check("late_res",  res1, 1'b0);
    check("late_cmpa", ca1, 4'hD);
    step();

    // Reset during WAIT.
    set_ops(2, 4'd5, 4'd1);
    req[2] = 1'b1;
    step();                    // t+1, WAIT
    req[2] = 1'b0;
    check("mid_busy", busy1, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_out", {gnt1, done1, res1, busy1, ca1, cb1}, 18'h0);
    check("mid_rst_oth", {gnt0, busy0, gnt3, busy3}, 10'h0);
    step();
    reset = 1'b0;
    step();
    step();
    check("mid_nodone", {done0, done1, done3}, 12'h0);

    // Requests 1 and 0 together on all latencies.
    set_ops(0, 4'd2, 4'hE);    // 2 > -2 -> 1
    set_ops(1, 4'hC, 4'd3);    // -4 > 3 -> 0
    req = 4'b0011;
    step();                    // t+1
    check("lat_gnt", {gnt0, gnt1, gnt3}, 12'h111);
    check("lat_nodone1", {done0, done1, done3}, 12'h0);
    req[0] = 1'b0;
    step();                    // t+2
    check("lat0_done", {done0, done1, done3}, 12'h100);
    check("lat0_res", res0, 1'b1);
    step();                    // t+3
    check("lat1_done", {done0, done1, done3}, 12'h010);
    step();                    // t+4
    check("lat0_next", gnt0, 4'b0010);
    check("lat3_nodone", done3, 4'b0000);
    step();                    // t+5
    check("lat3_done", done3, 4'b0001);
    check("lat3_res", res3, 1'b1);
    check("lat1_next", gnt1, 4'b0010);
    req = '0;
    for (int k = 0; k < 8; k++) step();
    check("final_idle", {busy0, busy1, busy3}, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/signed_cmp_arbiter.md
# signed_cmp_arbiter

Round-robin arbiter and sequencer that shares one registered signed comparator (`signed_num`, result on `res`) among up to `N_REQ` requesters. Each requester posts a signed operand pair with a level request. The block grants one requester at a time, latches its operands onto the comparator inputs and waits the comparator latency. It then returns the 1-bit result with a one-cycle done pulse. It sits between the requesting datapath units and the single comparator instance.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `WIDTH`, 4, operand width, two's complement
- `CMP_LAT`, 1, comparator input-to-`res` latency in cycles (0..7; 0 = combinational)

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `req`  in  N_REQ  level request per requester
- `a_bus`  in  N_REQ*WIDTH  operand a; requester i at [i*WIDTH +: WIDTH]
- `b_bus`  in  N_REQ*WIDTH  operand b; same packing
- `gnt`  out  N_REQ  one-hot grant, high from grant cycle through done cycle
- `done`  out  N_REQ  one-cycle pulse to the granted requester when its result is valid
- `res`  out  1  comparison result; valid in the `done` cycle; holds its value otherwise
- `busy`  out  1  high whenever state is not IDLE
- `cmp_a`, `cmp_b`  out  WIDTH  registered operands to the comparator
- `cmp_res`  in  1  comparator result

## Operation
- States:
  - IDLE: if any `req` bit is set, pick a winner by round-robin, latch its `a`/`b` into `cmp_a`/`cmp_b`, set `gnt`, load wait counter with `CMP_LAT`, go to WAIT.
  - WAIT: if the counter is 0, capture `cmp_res` into `res` and go to DONE; otherwise decrement.
  - DONE: pulse `done[winner]`, hold `gnt`, go to IDLE.
- Round-robin: search starts at (last_winner+1) mod N_REQ. After reset last_winner = N_REQ-1, so index 0 has highest priority.
- `req` is sampled only in IDLE. Deasserting or changing operands after grant has no effect. The operation completes and `done` still pulses.
- Holding `req` through `done` is treated as a new request in the following IDLE cycle.
- `cmp_a`/`cmp_b` hold the last issued operands while idle. No arithmetic is done in this block. Widths pass through unchanged.
- Comparator semantics are owned by `signed_num`. For the bench model: `res` = 1 iff $signed(a) > $signed(b).

## Timing
- Reset (asynchronous, immediate): state=IDLE; `gnt`, `done`, `res`, `busy`, `cmp_a`, `cmp_b` = 0; last_winner = N_REQ-1.
- Reset mid-operation: the in-flight comparison is dropped and no `done` is issued.
- Request seen in IDLE at cycle t:
  - `gnt`, `busy` and operands are valid from t+1.
  - WAIT spans t+1 .. t+1+CMP_LAT.
  - `done` and `res` are valid at t+2+CMP_LAT.
  - IDLE is reached at t+3+CMP_LAT.
- Throughput: one comparison per CMP_LAT+3 cycles.
- Only one `gnt` bit and at most one `done` bit are ever high.
- `busy` = 1 from t+1 through the DONE cycle.
- Simultaneous requests: the single round-robin winner is chosen; the others wait in IDLE order.

## Test plan
- Single request, CMP_LAT=1: req[0] at cycle t with a=4, b=1 -> `gnt[0]` from t+1, `cmp_a`=4, `cmp_b`=1, `done[0]` and `res`=1 at t+3, IDLE at t+4.
- Signed check: a=4, b=4'hF (-1) -> `res`=1. Then a=4'hF, b=4 -> `res`=0 (an unsigned implementation would invert both).
- All four requests from reset, held until each one's `done` -> grants 0,1,2,3. `done` at t+3, t+7, t+11, t+15. Each `res` matches its own operand pair.
- Fairness: req[0] held permanently plus req[2] -> grant order 0,2,0,2. req[2] never starves.
- Operand change after grant: req[1] a=-3, b=2, then a=7 from t+2 -> `res`=0, computed on the latched -3 vs 2.
- Reset asserted during WAIT -> all outputs 0 immediately, no `done`. After release, requests 1 and 0 together -> 0 is granted first. Repeat with CMP_LAT=0 and 3: `done` at t+2 and t+5 respectively.
